// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - stallable burst sequencer for the 8-bit code-sequence datapath
//
// Emits `count` codes (0 => 16) from the cycle 0,3,12,34,59,233,24,1,155 over a
// valid/ready handshake, then pulses `done` for one cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   burst request, sampled in IDLE only
//   stop     in   abort request, effective in RUN only
//   count    in   burst length latched on start, 0 means 16
//   z        out  current code, 0 when z_valid is low
//   z_valid  out  z holds a valid code
//   z_ready  in   consumer accepts z this cycle
//   idx      out  table index of the current code
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse on normal completion
//   z_par    out  even-parity bit over z (only with SEQ_PARITY_EN defined)
//
// Build option: define SEQ_PARITY_EN to add the z_par output.

module seq_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       count,
  output logic [7:0]       z,
  output logic             z_valid,
  input  logic             z_ready,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
`ifdef SEQ_PARITY_EN
  output logic             done,
  output logic             z_par
`else
  output logic             done
`endif
);

  localparam int SEQ_LEN = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [4:0]       remaining;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       code_next;

  function automatic logic [7:0] code_at(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       code_at = 8'd0;
      1:       code_at = 8'd3;
      2:       code_at = 8'd12;
      3:       code_at = 8'd34;
      4:       code_at = 8'd59;
      5:       code_at = 8'd233;
      6:       code_at = 8'd24;
      7:       code_at = 8'd1;
      8:       code_at = 8'd155;
      default: code_at = 8'd0;
    endcase
  endfunction

  // Index and code presented after a transfer; both depend on registered idx only.
  assign idx_next  = (idx == IDX_W'(SEQ_LEN - 1)) ? '0 : idx + IDX_W'(1);
  assign code_next = code_at(idx_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= 5'd0;
      z         <= 8'd0;
      z_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_PARITY_EN
      z_par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_RUN;
            remaining <= (count == 4'd0) ? 5'd16 : {1'b0, count};
            idx       <= '0;
            z         <= code_at('0);
            z_valid   <= 1'b1;
            busy      <= 1'b1;
`ifdef SEQ_PARITY_EN
            z_par     <= ^code_at('0);
`endif
          end
        end

        S_RUN: begin
          if (stop) begin
            // A coincident transfer already happened on the bus; idx is left
            // where it was and the remaining count is thrown away.
            state     <= S_IDLE;
            remaining <= 5'd0;
            z         <= 8'd0;
            z_valid   <= 1'b0;
            busy      <= 1'b0;
`ifdef SEQ_PARITY_EN
            z_par     <= 1'b0;
`endif
          end else if (z_ready) begin
            idx       <= idx_next;
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) begin
              state   <= S_DONE;
              z       <= 8'd0;
              z_valid <= 1'b0;
              done    <= 1'b1;
`ifdef SEQ_PARITY_EN
              z_par   <= 1'b0;
`endif
            end else begin
              z       <= code_next;
`ifdef SEQ_PARITY_EN
              z_par   <= ^code_next;
`endif
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          remaining <= 5'd0;
          z         <= 8'd0;
          z_valid   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
`ifdef SEQ_PARITY_EN
          z_par     <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl against a queue-based burst model

module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       z_ready = 1'b0;
  logic [3:0] count = 4'd0;
  logic [7:0] z;
  logic       z_valid;
  logic [3:0] idx;
  logic       busy;
  logic       done;
`ifdef SEQ_PARITY_EN
  logic       z_par;
`endif

  seq_ctrl #(.IDX_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .count   (count),
    .z       (z),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .idx     (idx),
    .busy    (busy),
`ifdef SEQ_PARITY_EN
    .done    (done),
    .z_par   (z_par)
`else
    .done    (done)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int codes [9] = '{0, 3, 12, 34, 59, 233, 24, 1, 155};

  // Model: the codes still owed to the consumer, how many were already taken,
  // and whether the completion cycle is pending.
  int q[$];
  int pos = 0;
  bit in_burst = 0;
  bit done_pend = 0;

  int xlog[$];
  int n_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("z_valid", int'(z_valid), int'(in_burst));
    chk("z", int'(z), in_burst ? q[0] : 0);
    chk("idx", int'(idx), pos % 9);
    chk("busy", int'(busy), int'(in_burst || done_pend));
    chk("done", int'(done), int'(done_pend));
`ifdef SEQ_PARITY_EN
    chk("z_par", int'(z_par), in_burst ? ($countones(q[0]) % 2) : 0);
`endif
  endtask

  // Called just after a falling edge: check, drive, advance the model, move one cycle.
  task automatic step(input bit s, input bit p, input bit r, input int c);
    compare_outputs();
    start   = s;
    stop    = p;
    z_ready = r;
    count   = c[3:0];
    if (z_valid && r) xlog.push_back(int'(z));
    if (done) n_done++;
    if (done_pend) begin
      done_pend = 0;
    end else if (in_burst) begin
      if (p) begin
        in_burst = 0;
        q.delete();
      end else if (r) begin
        void'(q.pop_front());
        pos++;
        if (q.size() == 0) begin
          in_burst  = 0;
          done_pend = 1;
        end
      end
    end else if (s) begin
      int n;
      n = (c[3:0] == 4'd0) ? 16 : int'(c[3:0]);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(codes[i % 9]);
      pos = 0;
      in_burst = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_z", int'(z), 0);
    chk("rst_z_valid", int'(z_valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
`ifdef SEQ_PARITY_EN
    chk("rst_z_par", int'(z_par), 0);
`endif
    q.delete();
    pos = 0;
    in_burst = 0;
    done_pend = 0;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_log();
    xlog.delete();
    n_done = 0;
  endtask

  initial begin
    int exp11 [11] = '{0, 3, 12, 34, 59, 233, 24, 1, 155, 0, 3};
    int bp [7] = '{1, 0, 0, 1, 1, 0, 1};

    do_reset();

    // Basic burst of 3.
    clear_log();
    step(1, 0, 1, 3);
    repeat (5) step(0, 0, 1, 0);
    chk("basic_len", xlog.size(), 3);
    if (xlog.size() == 3) begin
      chk("basic_z0", xlog[0], 0);
      chk("basic_z1", xlog[1], 3);
      chk("basic_z2", xlog[2], 12);
    end
    chk("basic_done", n_done, 1);
    chk("basic_idx", int'(idx), 3);

    // Wrap through the table with 11 codes.
    clear_log();
    step(1, 0, 1, 11);
    repeat (13) step(0, 0, 1, 0);
    chk("wrap_len", xlog.size(), 11);
    if (xlog.size() == 11)
      for (int i = 0; i < 11; i++) chk($sformatf("wrap_z%0d", i), xlog[i], exp11[i]);
    chk("wrap_done", n_done, 1);
    chk("wrap_idx", int'(idx), 2);

    // count = 0 means 16.
    clear_log();
    step(1, 0, 1, 0);
    repeat (18) step(0, 0, 1, 0);
    chk("len16", xlog.size(), 16);
    chk("len16_done", n_done, 1);

    // Backpressure pattern on a burst of 4.
    clear_log();
    step(1, 0, 1, 4);
    for (int i = 0; i < 7; i++) step(0, 0, bp[i][0], 0);
    repeat (3) step(0, 0, 1, 0);
    chk("bp_len", xlog.size(), 4);
    if (xlog.size() == 4) begin
      chk("bp_z0", xlog[0], 0);
      chk("bp_z1", xlog[1], 3);
      chk("bp_z2", xlog[2], 12);
      chk("bp_z3", xlog[3], 34);
    end
    chk("bp_done", n_done, 1);

    // Abort on the 2nd transfer of a 5-code burst.
    clear_log();
    step(1, 0, 1, 5);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    chk("abort_len", xlog.size(), 2);
    chk("abort_no_done", n_done, 0);
    chk("abort_busy", int'(busy), 0);

    // start during RUN is ignored.
    clear_log();
    step(1, 0, 1, 5);
    step(0, 0, 0, 0);
    step(1, 0, 0, 9);
    repeat (8) step(0, 0, 1, 0);
    chk("ign_len", xlog.size(), 5);
    chk("ign_done", n_done, 1);

    // Reset during the 3rd code, then a fresh burst of 2.
    step(1, 0, 1, 6);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    do_reset();
    clear_log();
    step(1, 0, 1, 2);
    repeat (4) step(0, 0, 1, 0);
    chk("rstmid_len", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("rstmid_z0", xlog[0], 0);
      chk("rstmid_z1", xlog[1], 3);
    end
    chk("rstmid_done", n_done, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
